// File: rtl/contador_ctrl.sv
// contador_ctrl: run/pause/idle sequencer for the iCEstick 5-LED binary counter.
// A prescaler of N bits produces one count step every 2^N clocks while running.
// Buttons are level inputs already synchronized to clk; each rising edge is one command.
// Optional build macro CONTADOR_PINGPONG_EN: the count bounces at 0 and 31 instead of wrapping.
module contador_ctrl #(
   parameter int N = 22
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_stop,
   input  logic       btn_dir,
   output logic [4:0] leds,
   output logic       running,
   output logic       tick
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

   logic [1:0]   state, state_nx;
   logic [4:0]   count, count_nx;
   logic         dir, dir_nx;
   logic [N-1:0] presc, presc_nx;

   // Previous-cycle button levels for rising-edge detection
   logic         start_p0, stop_p0, dirb_p0;
   logic         start_cmd, stop_cmd, dir_cmd;

   // Plain modulo-32 step in the current direction
   function automatic logic [4:0] step_wrap(input logic [4:0] c, input logic d);
      return (d == DIR_UP) ? c + 5'd1 : c - 5'd1;
   endfunction

`ifdef CONTADOR_PINGPONG_EN
   // Step that reflects off the ends; returns {new_dir, new_count}
   function automatic logic [5:0] step_bounce(input logic [4:0] c, input logic d);
      if (d == DIR_UP && c == 5'd31) return {DIR_DN, 5'd30};
      if (d == DIR_DN && c == 5'd0)  return {DIR_UP, 5'd1};
      return {d, step_wrap(c, d)};
   endfunction

   logic [5:0] bnc;
`endif

   assign start_cmd = btn_start & ~start_p0;
   assign stop_cmd  = btn_stop  & ~stop_p0;
   assign dir_cmd   = btn_dir   & ~dirb_p0;

   // Tick is the last prescaler value while running; the step happens on that edge
   assign tick    = (state == ST_RUN) && (presc == '1);
   assign running = (state == ST_RUN);
   assign leds    = count;

   // Next-state logic: stop outranks start, direction toggles independently
   always_comb begin
      state_nx = state;
      count_nx = count;
      dir_nx   = dir ^ dir_cmd;
      presc_nx = '0;
`ifdef CONTADOR_PINGPONG_EN
      bnc      = step_bounce(count, dir);
`endif
      case (state)
         ST_IDLE: begin
            count_nx = '0;
            if (start_cmd) state_nx = ST_RUN;
         end
         ST_RUN: begin
            if (stop_cmd) begin
               // A stop on a tick cycle freezes the count without stepping
               state_nx = ST_PAUSE;
            end else begin
               presc_nx = presc + 1'b1;
               if (tick) begin
`ifdef CONTADOR_PINGPONG_EN
                  count_nx = bnc[4:0];
                  // A bounce forces the direction and overrides a coincident toggle
                  if (bnc[5] != dir) dir_nx = bnc[5];
`else
                  count_nx = step_wrap(count, dir);
`endif
               end
            end
         end
         ST_PAUSE: begin
            if (stop_cmd) begin
               state_nx = ST_IDLE;
               count_nx = '0;
            end else if (start_cmd) begin
               state_nx = ST_RUN;
            end
         end
         default: begin
            state_nx = ST_IDLE;
            count_nx = '0;
         end
      endcase
   end

   // State, count, direction, prescaler and button history registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         count    <= '0;
         dir      <= DIR_UP;
         presc    <= '0;
         start_p0 <= 1'b0;
         stop_p0  <= 1'b0;
         dirb_p0  <= 1'b0;
      end else begin
         state    <= state_nx;
         count    <= count_nx;
         dir      <= dir_nx;
         presc    <= presc_nx;
         start_p0 <= btn_start;
         stop_p0  <= btn_stop;
         dirb_p0  <= btn_dir;
      end
   end

endmodule

// File: tb/tb_contador_ctrl.sv
// tb_contador_ctrl: directed bench for contador_ctrl with N=2 (one step every 4 clocks).
// A behavioural model tracks mode, count, direction and cycles-in-run; a compare
// process checks it against the DUT on every falling edge, and literal checks pin it.
`timescale 1ns/1ps
module tb_contador_ctrl;

   localparam int N   = 2;
   localparam int PER = 1 << N;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       btn_start = 1'b0;
   logic       btn_stop  = 1'b0;
   logic       btn_dir   = 1'b0;
   logic [4:0] leds;
   logic       running;
   logic       tick;

   int n_cmp    = 0;
   int n_bad    = 0;
   int tick_cnt = 0;

   // Model: mode 0=idle 1=run 2=pause
   int m_mode  = 0;
   int m_count = 0;
   bit m_up    = 1'b1;
   int m_cyc   = 0;
   bit h_s = 1'b0, h_p = 1'b0, h_d = 1'b0;

   contador_ctrl #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_start (btn_start),
      .btn_stop  (btn_stop),
      .btn_dir   (btn_dir),
      .leds      (leds),
      .running   (running),
      .tick      (tick)
   );

   always #5 clk = ~clk;

   function automatic bit model_tick();
      return (m_mode == 1) && ((m_cyc % PER) == PER - 1);
   endfunction

   // Model update on each clock edge, reset immediately on rst
   always @(posedge clk or posedge rst) begin
      bit s, p, d, tk, flip;
      if (rst) begin
         m_mode = 0; m_count = 0; m_up = 1'b1; m_cyc = 0;
         h_s = 1'b0; h_p = 1'b0; h_d = 1'b0;
      end else begin
         s    = btn_start && !h_s;
         p    = btn_stop  && !h_p;
         d    = btn_dir   && !h_d;
         tk   = model_tick();
         flip = d;
         case (m_mode)
            0: if (s) begin m_mode = 1; m_cyc = 0; end
            1: begin
               if (p) m_mode = 2;
               else begin
                  if (tk) begin
`ifdef CONTADOR_PINGPONG_EN
                     if (m_up && m_count == 31) begin m_count = 30; m_up = 1'b0; flip = 1'b0; end
                     else if (!m_up && m_count == 0) begin m_count = 1; m_up = 1'b1; flip = 1'b0; end
                     else m_count = m_up ? m_count + 1 : m_count - 1;
`else
                     m_count = (m_count + (m_up ? 1 : 31)) % 32;
`endif
                  end
                  m_cyc++;
               end
            end
            default: begin
               if (p) begin m_mode = 0; m_count = 0; end
               else if (s) begin m_mode = 1; m_cyc = 0; end
            end
         endcase
         if (flip) m_up = !m_up;
         h_s = btn_start; h_p = btn_stop; h_d = btn_dir;
      end
   end

   // Per-cycle comparison against the model on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         n_cmp++;
         if (leds !== 5'(m_count) || running !== (m_mode == 1) || tick !== model_tick()) begin
            n_bad++;
            $display("FAIL model t=%0t leds=%0d want %0d running=%b want %b tick=%b want %b",
                     $time, leds, m_count, running, (m_mode == 1), tick, model_tick());
         end
         if (tick === 1'b1) tick_cnt++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_tick(output int waited);
      waited = 0;
      while (tick !== 1'b1 && waited < 64) begin
         cyc(1);
         waited++;
      end
      if (tick !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_tick: got no tick after %0d cycles, expected one within 64", waited);
      end
   endtask

   task automatic step_n(input int k);
      int w;
      repeat (k) begin
         wait_tick(w);
         cyc(1);
      end
   endtask

   task automatic pulse_start();
      btn_start = 1'b1; cyc(1); btn_start = 1'b0; cyc(1);
   endtask

   task automatic pulse_stop();
      btn_stop = 1'b1; cyc(1); btn_stop = 1'b0; cyc(1);
   endtask

   task automatic pulse_dir();
      btn_dir = 1'b1; cyc(1); btn_dir = 1'b0; cyc(1);
   endtask

   initial begin
      int w, t0;
      // Reset and idle
      cyc(3);
      rst = 1'b0;
      cyc(20);
      chk("idle_leds", leds, 0);
      chk("idle_running", running, 0);
      chk("idle_no_tick", tick_cnt, 0);

      // Start and count up; running is visible right after the start edge
      btn_start = 1'b1; cyc(1);
      chk("start_running", running, 1);
      btn_start = 1'b0; cyc(1);
      wait_tick(w);
      chk("first_tick_latency", w, 2);   // two of the four run cycles elapsed already
      cyc(1);
      chk("count_1", leds, 1);
      wait_tick(w);
      chk("tick_period", w, 3);
      cyc(1);
      step_n(2);
      chk("count_4", leds, 4);

`ifndef CONTADOR_PINGPONG_EN
      // Wrap up and down
      step_n(27);
      chk("count_31", leds, 31);
      step_n(1);
      chk("wrap_up_0", leds, 0);
      pulse_dir();
      step_n(1);
      chk("wrap_down_31", leds, 31);
      pulse_dir();
      step_n(6);
`else
      step_n(1);
`endif
      chk("count_5", leds, 5);

      // Pause, hold, resume, clear
      pulse_stop();
      chk("pause_running", running, 0);
      t0 = tick_cnt;
      cyc(20);
      chk("pause_hold", leds, 5);
      chk("pause_no_tick", tick_cnt - t0, 0);
      pulse_start();
      step_n(1);
      chk("resume_6", leds, 6);
      pulse_stop();
      pulse_stop();
      chk("clear_leds", leds, 0);
      chk("clear_running", running, 0);

      // Stop coincident with tick at 7
      pulse_start();
      step_n(7);
      chk("count_7", leds, 7);
      wait_tick(w);
      btn_stop = 1'b1; cyc(1); btn_stop = 1'b0;
      chk("stop_on_tick_leds", leds, 7);
      chk("stop_on_tick_running", running, 0);
      cyc(1);
      pulse_stop();
      chk("idle_again", leds, 0);

      // Direction edge coincident with tick at 3: step uses old direction
      pulse_start();
      step_n(3);
      chk("count_3", leds, 3);
      wait_tick(w);
      btn_dir = 1'b1; cyc(1); btn_dir = 1'b0;
      chk("dir_on_tick_up", leds, 4);
      step_n(1);
      chk("dir_next_down", leds, 3);

      // Held buttons give exactly one command each
      pulse_stop();
      btn_start = 1'b1; cyc(10); btn_start = 1'b0;
      chk("hold_start_running", running, 1);
      btn_stop = 1'b1; cyc(10); btn_stop = 1'b0; cyc(1);
      chk("hold_stop_leds", leds, 1);
      chk("hold_stop_running", running, 0);

      // Asynchronous reset between edges while a tick is pending
      pulse_start();
      cyc(2);
      chk("pre_rst_leds", leds, 1);
      chk("pre_rst_tick", tick, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_leds", leds, 0);
      chk("async_rst_running", running, 0);
      chk("async_rst_tick", tick, 0);
      cyc(2);
      rst = 1'b0;
      cyc(2);

`ifdef CONTADOR_PINGPONG_EN
      // Bounce at both ends; a dir edge on the bottom bounce is discarded
      pulse_start();
      step_n(30);
      chk("pp_30", leds, 30);
      step_n(1);
      chk("pp_31", leds, 31);
      step_n(1);
      chk("pp_bounce_30", leds, 30);
      step_n(1);
      chk("pp_29", leds, 29);
      step_n(28);
      chk("pp_1", leds, 1);
      step_n(1);
      chk("pp_0", leds, 0);
      wait_tick(w);
      btn_dir = 1'b1; cyc(1); btn_dir = 1'b0;
      chk("pp_bounce_1", leds, 1);
      step_n(1);
      chk("pp_2", leds, 2);
`else
      // Down-count wrap after reset restores direction up
      pulse_start();
      pulse_dir();
      step_n(1);
      chk("post_rst_down_wrap", leds, 31);
`endif

      cyc(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation reached 200000 ns without completing");
      $fatal(1, "timeout");
   end

endmodule
